// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller word port between fetch (m0) and load/store (m1).
// Optional busy watchdog with per-port err outputs: define SRAM_ARB_TIMEOUT_EN.
module sram_arbiter #(
    parameter int unsigned ADDR_W         = 30,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m0_re,
    input  logic              m1_re,
    input  logic              m0_we,
    input  logic              m1_we,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_read_sync,
    input  logic              mem_write_sync
`ifdef SRAM_ARB_TIMEOUT_EN
    ,
    output logic              m0_err,
    output logic              m1_err
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_e;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                gnt_q, gnt_d;
    logic                is_write_q, is_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_re_q, mem_re_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
    logic                m0_ack_q, m0_ack_d;
    logic                m1_ack_q, m1_ack_d;

    logic req0, req1, done;
    assign req0 = m0_re | m0_we;
    assign req1 = m1_re | m1_we;
    assign done = is_write_q ? mem_write_sync : mem_read_sync;

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             m0_err_q, m0_err_d;
    logic             m1_err_q, m1_err_d;
    logic             expired;

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state, grant and completion logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        is_write_d   = is_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_re_d     = mem_re_q;
        mem_we_d     = mem_we_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
`ifdef SRAM_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        m0_err_d     = 1'b0;
        m1_err_d     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                // On a tie the port that did not win last time is granted
                if (req0 && (!req1 || last_grant_q)) begin
                    gnt_d       = 1'b0;
                    mem_addr_d  = m0_addr;
                    mem_wdata_d = m0_wdata;
                    is_write_d  = !m0_re;
                    mem_re_d    = m0_re;
                    mem_we_d    = !m0_re;
                    state_d     = BUSY;
`ifdef SRAM_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end else if (req1) begin
                    gnt_d       = 1'b1;
                    mem_addr_d  = m1_addr;
                    mem_wdata_d = m1_wdata;
                    is_write_d  = !m1_re;
                    mem_re_d    = m1_re;
                    mem_we_d    = !m1_re;
                    state_d     = BUSY;
`ifdef SRAM_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end

            BUSY: begin
                if (done) begin
                    m0_ack_d     = !gnt_q;
                    m1_ack_d     = gnt_q;
                    if (!is_write_q && !gnt_q) m0_rdata_d = mem_rdata;
                    if (!is_write_q &&  gnt_q) m1_rdata_d = mem_rdata;
                    mem_re_d     = 1'b0;
                    mem_we_d     = 1'b0;
                    last_grant_d = gnt_q;
                    state_d      = RELEASE;
                end
`ifdef SRAM_ARB_TIMEOUT_EN
                else if (expired) begin
                    m0_ack_d     = !gnt_q;
                    m1_ack_d     = gnt_q;
                    m0_err_d     = !gnt_q;
                    m1_err_d     = gnt_q;
                    mem_re_d     = 1'b0;
                    mem_we_d     = 1'b0;
                    last_grant_d = gnt_q;
                    state_d      = RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            RELEASE: state_d = IDLE;

            default: begin
                state_d  = IDLE;
                mem_re_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            is_write_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            is_write_q   <= is_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
        end
    end

`ifdef SRAM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            m0_err_q <= m0_err_d;
            m1_err_q <= m1_err_d;
        end
    end

    assign m0_err = m0_err_q;
    assign m1_err = m1_err_q;
`endif

    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;

endmodule
